// File: rtl/intersection_pkg.sv
// intersection_pkg: shared encodings and state type for the intersection command sequencer
package intersection_pkg;
  localparam logic [1:0] OP_REM_A = 2'b00;
  localparam logic [1:0] OP_REM_B = 2'b01;
  localparam logic [1:0] OP_ADD_A = 2'b10;
  localparam logic [1:0] OP_ADD_B = 2'b11;
  localparam logic [2:0] MODE_DISPLAY = 3'b100;
  localparam int DEF_MAX_CARS = 30;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} seq_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags, push+pop allowed when full
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign cnt_nx  = cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt_nx;
      full <= cnt_nx == (AW+1)'(DEPTH);
      empty <= cnt_nx == '0;
    end
  end
endmodule

// File: rtl/intersection_cmd_sequencer.sv
// intersection_cmd_sequencer: buffers car add/remove requests and strobes them into the simulator
module intersection_cmd_sequencer
  import intersection_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_CARS   = DEF_MAX_CARS,
  parameter int ACT_HIGH   = 2,
  parameter int ACT_GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic [4:0] req_plate,
  output logic       req_ready,
  input  logic       disp_req,
  output logic [2:0] mode,
  output logic [4:0] plateIn,
  output logic       action,
  output logic [4:0] cnt_a,
  output logic [4:0] cnt_b,
  output logic [7:0] drop_cnt,
  output logic       busy
);
  localparam int PW = $clog2(ACT_HIGH > ACT_GAP ? ACT_HIGH : ACT_GAP) + 1;
  seq_state_t state;
  logic [PW-1:0] ph;
  logic [2:0] last_mode;
  logic [6:0] head;
  logic [1:0] head_op;
  logic [4:0] head_cnt;
  logic full, empty, pop, drop;
  assign req_ready = !full;
  assign head_op   = head[6:5];
  assign head_cnt  = head_op[0] ? cnt_b : cnt_a;
  assign drop      = head_op[1] ? head_cnt == 5'(MAX_CARS) : head_cnt == 5'd0;
  assign pop       = state == IDLE && !empty;
  assign busy      = state != IDLE || !empty;
  sync_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(req_valid && req_ready),
    .pop(pop),
    .din({req_op, req_plate}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph <= '0;
      mode <= 3'b000;
      last_mode <= 3'b000;
      plateIn <= 5'd0;
      action <= 1'b0;
      cnt_a <= 5'd0;
      cnt_b <= 5'd0;
      drop_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && !drop) begin
            mode <= {1'b0, head_op};
            last_mode <= {1'b0, head_op};
            plateIn <= head[4:0];
            state <= SETUP;
          end else begin
            mode <= (empty && disp_req) ? MODE_DISPLAY : last_mode;
            drop_cnt <= drop_cnt + {7'd0, pop && drop_cnt != 8'hff};
          end
        end
        SETUP: begin
          state <= PULSE;
          action <= 1'b1;
          ph <= '0;
          // mode holds the op being issued: bit1 = add, bit0 = road B
          if (mode[0]) cnt_b <= mode[1] ? cnt_b + 5'd1 : cnt_b - 5'd1;
          else cnt_a <= mode[1] ? cnt_a + 5'd1 : cnt_a - 5'd1;
        end
        PULSE: begin
          if (ph == PW'(ACT_HIGH - 1)) begin
            state <= GAP;
            action <= 1'b0;
            ph <= '0;
          end else ph <= ph + 1'b1;
        end
        GAP: begin
          if (ph == PW'(ACT_GAP - 1)) state <= IDLE;
          else ph <= ph + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intersection_cmd_sequencer.sv
// tb_intersection_cmd_sequencer: directed-vector bench for the intersection command sequencer
module tb_intersection_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_plate = 5'd0;
  logic disp_req = 1'b0;
  logic req_ready, action, busy;
  logic [2:0] mode;
  logic [4:0] plateIn, cnt_a, cnt_b;
  logic [7:0] drop_cnt;
  int vectors = 0;
  int miscompares = 0;
  int pulse_plate[$];
  int pulse_mode[$];
  logic prev_action = 1'b0;
  logic saw_full = 1'b0;

  intersection_cmd_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_plate(req_plate),
    .req_ready(req_ready), .disp_req(disp_req), .mode(mode), .plateIn(plateIn),
    .action(action), .cnt_a(cnt_a), .cnt_b(cnt_b), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (action && !prev_action) begin
      pulse_plate.push_back(int'(plateIn));
      pulse_mode.push_back(int'(mode));
    end
    prev_action = action;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [4:0] plate);
    int n;
    req_valid = 1'b1;
    req_op = op;
    req_plate = plate;
    n = 0;
    while (!req_ready && n < 50) begin
      saw_full = 1'b1;
      step();
      n++;
    end
    if (!req_ready) chk("push_timeout", 0, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int base;
    // 1: reset state and single addA timing
    reset_dut();
    chk("rst_mode", mode, 0);
    chk("rst_plate", plateIn, 0);
    chk("rst_action", action, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    req_valid = 1'b1; req_op = 2'b10; req_plate = 5'd17;
    step();
    req_valid = 1'b0;
    chk("t0_busy", busy, 1);
    chk("t0_action", action, 0);
    step();
    chk("t1_mode", mode, 2);
    chk("t1_plate", plateIn, 17);
    chk("t1_action", action, 0);
    step();
    chk("t2_action", action, 1);
    chk("t2_cnt_a", cnt_a, 1);
    step();
    chk("t3_action", action, 1);
    chk("t3_mode", mode, 2);
    step();
    chk("t4_action", action, 0);
    step();
    chk("t5_action", action, 0);
    chk("t5_busy", busy, 1);
    step();
    chk("t6_busy", busy, 0);
    // 2: remove from empty road B is dropped; addB then remB issue
    base = pulse_plate.size();
    push(2'b01, 5'd4);
    wait_idle(20);
    chk("remb_pulses", pulse_plate.size() - base, 0);
    chk("remb_drop", drop_cnt, 1);
    chk("remb_cnt_b", cnt_b, 0);
    push(2'b11, 5'd3);
    push(2'b01, 5'd0);
    wait_idle(40);
    chk("b_pulses", pulse_plate.size() - base, 2);
    chk("b_plate0", pulse_plate[base], 3);
    chk("b_mode0", pulse_mode[base], 3);
    chk("b_mode1", pulse_mode[base+1], 1);
    chk("b_cnt_b", cnt_b, 0);
    // 3: capacity limit on road A
    reset_dut();
    base = pulse_plate.size();
    for (int i = 0; i < 31; i++) push(2'b10, 5'(i));
    wait_idle(400);
    chk("cap_pulses", pulse_plate.size() - base, 30);
    chk("cap_cnt_a", cnt_a, 30);
    chk("cap_drop", drop_cnt, 1);
    push(2'b00, 5'd0);
    wait_idle(20);
    chk("cap_rem_pulses", pulse_plate.size() - base, 31);
    chk("cap_rem_cnt_a", cnt_a, 29);
    // 4: burst fills the FIFO, order preserved
    reset_dut();
    base = pulse_plate.size();
    saw_full = 1'b0;
    for (int i = 1; i <= 12; i++) push(i[0] ? 2'b10 : 2'b11, 5'(i));
    chk("burst_saw_full", saw_full, 1);
    wait_idle(200);
    chk("burst_pulses", pulse_plate.size() - base, 12);
    for (int i = 0; i < 12 && base + i < pulse_plate.size(); i++)
      chk($sformatf("burst_plate%0d", i), pulse_plate[base+i], i + 1);
    chk("burst_cnt_a", cnt_a, 6);
    chk("burst_cnt_b", cnt_b, 6);
    // 5: display mode while idle
    reset_dut();
    disp_req = 1'b1;
    step();
    step();
    chk("disp_mode", mode, 4);
    chk("disp_action", action, 0);
    chk("disp_busy", busy, 0);
    push(2'b10, 5'd9);
    step();
    chk("disp_pop_mode", mode, 2);
    chk("disp_pop_plate", plateIn, 9);
    wait_idle(20);
    chk("disp_gap_mode", mode, 2);
    step();
    chk("disp_back_mode", mode, 4);
    disp_req = 1'b0;
    // 6: reset during pulse discards the command and the queue
    reset_dut();
    push(2'b10, 5'd5);
    step();
    req_valid = 1'b1; req_op = 2'b11; req_plate = 5'd22;
    step();
    req_valid = 1'b0;
    chk("mid_action", action, 1);
    chk("mid_cnt_a", cnt_a, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_action", action, 0);
    chk("mid_rst_cnt_a", cnt_a, 0);
    chk("mid_rst_cnt_b", cnt_b, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    step();
    base = pulse_plate.size();
    push(2'b11, 5'd7);
    wait_idle(20);
    chk("post_pulses", pulse_plate.size() - base, 1);
    if (pulse_plate.size() > base) chk("post_plate", pulse_plate[base], 7);
    chk("post_cnt_b", cnt_b, 1);
    chk("post_cnt_a", cnt_a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
